// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction class codes and the queued decode record
// for the MIPS decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_J       = 3'd1,
    CLS_JAL     = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_LOAD    = 3'd4,
    CLS_STORE   = 3'd5,
    CLS_IMM     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } class_t;

  // Width-independent part of a queue entry; the DATA_W/PC_W-sized values live
  // in parallel arrays inside the stage.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    class_t     cls;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational MIPS decode: fields, extended immediate, jump target, class.
// Unsupported opcodes become CLS_ILLEGAL when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_comb
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   pc,
  output decoded_t          fields,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   jtarget
);

  logic [5:0]      opcode;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc4;

  assign opcode = instr[31:26];
  assign imm    = instr[15:0];
  assign pc4    = pc + PC_W'(4);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // statements leaves a variable unassigned and infers a latch.
    fields        = '0;
    fields.opcode = opcode;
    fields.rs     = instr[25:21];
    fields.rt     = instr[20:16];
    fields.rd     = instr[15:11];
    fields.shamt  = instr[10:6];
    fields.funct  = instr[5:0];

    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(DATA_W-16){1'b0}}, imm};
      OP_LUI:                   imm_ext = DATA_W'({imm, 16'h0000});
      default:                  imm_ext = {{(DATA_W-16){imm[15]}}, imm};
    endcase

    // Upper bits come from pc+4; the low 28 bits are the word index.
    jtarget       = pc4;
    jtarget[27:0] = {instr[25:0], 2'b00};

    case (opcode)
      OP_RTYPE:      fields.cls = CLS_R;
      OP_J:          fields.cls = CLS_J;
      OP_JAL:        fields.cls = CLS_JAL;
      OP_BEQ, OP_BNE: fields.cls = CLS_BRANCH;
      OP_LW:         fields.cls = CLS_LOAD;
      OP_SW:         fields.cls = CLS_STORE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      default: fields.cls = (opcode inside {[6'h08:6'h0F]}) ? CLS_IMM : CLS_ILLEGAL;
`else
      default: fields.cls = CLS_IMM;
`endif
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: decodes on push, queues DEPTH entries, valid/ready
// on both sides. Define DECODE_ILLEGAL_TRAP_EN for the ILLEGAL class and illegal_seen.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_shamt,
  output logic [5:0]               out_funct,
  output logic [DATA_W-1:0]        out_imm_ext,
  output logic [PC_W-1:0]          out_jtarget,
  output logic [2:0]               out_class,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                     illegal_seen
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, do_push;

  decoded_t          fld_q [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [PC_W-1:0]   jt_q  [DEPTH];
  logic [PC_W-1:0]   pc_q  [DEPTH];

  decoded_t          new_fld;
  logic [DATA_W-1:0] new_imm;
  logic [PC_W-1:0]   new_jt;
  decoded_t          head;

  decode_comb #(.DATA_W(DATA_W), .PC_W(PC_W)) u_decode_comb (
    .instr   (in_instr),
    .pc      (in_pc),
    .fields  (new_fld),
    .imm_ext (new_imm),
    .jtarget (new_jt)
  );

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign do_push   = push && !flush;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the statements are written in.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; outputs are masked with
  // out_valid, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fld_q[wr_ptr_q] <= new_fld;
      imm_q[wr_ptr_q] <= new_imm;
      jt_q[wr_ptr_q]  <= new_jt;
      pc_q[wr_ptr_q]  <= in_pc;
    end
  end

  assign head        = fld_q[rd_ptr_q];
  assign out_opcode  = out_valid ? head.opcode     : '0;
  assign out_rs      = out_valid ? head.rs         : '0;
  assign out_rt      = out_valid ? head.rt         : '0;
  assign out_rd      = out_valid ? head.rd         : '0;
  assign out_shamt   = out_valid ? head.shamt      : '0;
  assign out_funct   = out_valid ? head.funct      : '0;
  assign out_class   = out_valid ? 3'(head.cls)    : 3'd0;
  assign out_imm_ext = out_valid ? imm_q[rd_ptr_q] : '0;
  assign out_jtarget = out_valid ? jt_q[rd_ptr_q]  : '0;
  assign out_pc      = out_valid ? pc_q[rd_ptr_q]  : '0;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_seen_q, illegal_seen_d;

  // Sticky: survives flush, cleared only by reset.
  assign illegal_seen_d = illegal_seen_q || (do_push && new_fld.cls == CLS_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else        illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors plus
// hand-written backpressure, flush, reset and illegal-opcode sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm_ext, out_jtarget, out_pc;
  logic [2:0]  out_class;
  logic [1:0]  count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_seen;
  localparam logic [2:0] EXP_UNSUP_CLS = 3'd7;
`else
  localparam logic [2:0] EXP_UNSUP_CLS = 3'd6;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.DATA_W(32), .PC_W(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_funct   (out_funct),
    .out_imm_ext (out_imm_ext),
    .out_jtarget (out_jtarget),
    .out_class   (out_class),
    .out_pc      (out_pc),
    .count       (count)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_seen(illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [2:0]  cls;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            instr         pc            op     rs     rt     rd     sh     fn     imm           jt            cls
    vecs[0]  = '{32'h03E0E0EB, 32'h00400000, 6'h00, 5'd31, 5'd0,  5'd28, 5'd3,  6'h2B, 32'hFFFFE0EB, 32'h0F8383AC, 3'd0};
    vecs[1]  = '{32'h0A970CE9, 32'h00400000, 6'h02, 5'd20, 5'd23, 5'd1,  5'd19, 6'h29, 32'h00000CE9, 32'h0A5C33A4, 3'd1};
    vecs[2]  = '{32'h0E970CE9, 32'h00400000, 6'h03, 5'd20, 5'd23, 5'd1,  5'd19, 6'h29, 32'h00000CE9, 32'h0A5C33A4, 3'd2};
    vecs[3]  = '{32'h8FE055A6, 32'h00400000, 6'h23, 5'd31, 5'd0,  5'd10, 5'd22, 6'h26, 32'h000055A6, 32'h0F815698, 3'd4};
    vecs[4]  = '{32'h20008000, 32'h00400000, 6'h08, 5'd0,  5'd0,  5'd16, 5'd0,  6'h00, 32'hFFFF8000, 32'h00020000, 3'd6};
    vecs[5]  = '{32'h34008000, 32'h00400000, 6'h0D, 5'd0,  5'd0,  5'd16, 5'd0,  6'h00, 32'h00008000, 32'h00020000, 3'd6};
    vecs[6]  = '{32'h3C001234, 32'h00400000, 6'h0F, 5'd0,  5'd0,  5'd2,  5'd8,  6'h34, 32'h12340000, 32'h000048D0, 3'd6};
    vecs[7]  = '{32'hAC000004, 32'h00400000, 6'h2B, 5'd0,  5'd0,  5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000010, 3'd5};
    vecs[8]  = '{32'h1000FFFF, 32'h00400000, 6'h04, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'h0003FFFC, 3'd3};
    vecs[9]  = '{32'h08000001, 32'hF0000000, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 32'h00000001, 32'hF0000004, 3'd1};
    vecs[10] = '{32'h14000000, 32'h0FFFFFFC, 6'h05, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 32'h10000000, 3'd3};
    vecs[11] = '{32'hFC000000, 32'h00400000, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 32'h00000000, EXP_UNSUP_CLS};

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    do_reset();
    check("rst.count",     count,       0);
    check("rst.out_valid", out_valid,   0);
    check("rst.in_ready",  in_ready,    1);
    check("rst.out_pc",    out_pc,      0);
    check("rst.out_imm",   out_imm_ext, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("rst.illegal_seen", illegal_seen, 0);
`endif

    // Table: push one word, check it one cycle later, then pop it.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].instr, vecs[i].pc);
      #1;
      check($sformatf("v%0d.no_comb_path", i), out_valid, 0);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d.out_valid", i), out_valid,   1);
      check($sformatf("v%0d.count", i),     count,       1);
      check($sformatf("v%0d.opcode", i),    out_opcode,  vecs[i].op);
      check($sformatf("v%0d.rs", i),        out_rs,      vecs[i].rs);
      check($sformatf("v%0d.rt", i),        out_rt,      vecs[i].rt);
      check($sformatf("v%0d.rd", i),        out_rd,      vecs[i].rd);
      check($sformatf("v%0d.shamt", i),     out_shamt,   vecs[i].sh);
      check($sformatf("v%0d.funct", i),     out_funct,   vecs[i].fn);
      check($sformatf("v%0d.imm_ext", i),   out_imm_ext, vecs[i].imm);
      check($sformatf("v%0d.jtarget", i),   out_jtarget, vecs[i].jt);
      check($sformatf("v%0d.class", i),     out_class,   vecs[i].cls);
      check($sformatf("v%0d.pc", i),        out_pc,      vecs[i].pc);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d.popped", i), out_valid, 0);
    end

    // Backpressure: fill to DEPTH, third word must wait until a slot frees.
    drive(32'hAC000001, 32'h00001000);
    check("bp.ready0", in_ready, 1);
    tick();
    check("bp.count1", count, 1);
    drive(32'hAC000002, 32'h00001004);
    check("bp.ready1", in_ready, 1);
    tick();
    check("bp.count2", count, 2);
    check("bp.full_not_ready", in_ready, 0);
    drive(32'hAC000003, 32'h00001008);
    tick();
    check("bp.hold_count", count, 2);
    check("bp.hold_ready", in_ready, 0);
    check("bp.hold_head",  out_pc, 32'h00001000);
    out_ready = 1'b1;
    tick();
    check("bp.pop_a_count", count, 1);
    check("bp.pop_a_head",  out_pc, 32'h00001004);
    tick();
    check("bp.pushpop_count", count, 1);
    check("bp.pushpop_head",  out_pc, 32'h00001008);
    check("bp.pushpop_funct", out_funct, 3);
    in_valid = 1'b0;
    tick();
    check("bp.empty_count", count, 0);
    check("bp.empty_valid", out_valid, 0);
    check("bp.empty_pc",    out_pc, 0);
    check("bp.empty_funct", out_funct, 0);
    out_ready = 1'b0;

    // Flush while full with a push offered.
    drive(32'hAC000001, 32'h00002000);
    tick();
    drive(32'hAC000002, 32'h00002004);
    tick();
    check("fl.full", count, 2);
    drive(32'hAC000004, 32'h00002008);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.count",    count, 0);
    check("fl.valid",    out_valid, 0);
    check("fl.in_ready", in_ready, 1);

    // Flush with room: the offered word is still discarded.
    drive(32'hAC000001, 32'h00002100);
    tick();
    drive(32'hAC000005, 32'h00002104);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2.count", count, 0);
    check("fl2.valid", out_valid, 0);
    drive(32'hAC000006, 32'h00003000);
    tick();
    in_valid = 1'b0;
    check("fl2.after_count", count, 1);
    check("fl2.after_head",  out_pc, 32'h00003000);
    check("fl2.after_funct", out_funct, 6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-stream with a push offered.
    drive(32'hAC000001, 32'h00004000);
    tick();
    drive(32'hAC000002, 32'h00004004);
    tick();
    drive(32'hAC000007, 32'h00004008);
    rst_n = 1'b0;
    tick();
    check("mr.count",    count, 0);
    check("mr.valid",    out_valid, 0);
    check("mr.in_ready", in_ready, 1);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("mr.after_count", count, 0);

`ifdef DECODE_ILLEGAL_TRAP_EN
    do_reset();
    check("il.clear", illegal_seen, 0);
    drive(32'hFC000000, 32'h00005000);
    tick();
    in_valid = 1'b0;
    check("il.class", out_class, 7);
    check("il.seen",  illegal_seen, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("il.flush_count", count, 0);
    check("il.sticky",      illegal_seen, 1);
    do_reset();
    check("il.reset_clear", illegal_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised MIPS instruction decode stage with valid/ready handshakes on both sides.
- Sits between instruction fetch and register read/execute in the CPU pipeline.
- Decodes each accepted instruction into its fields, an extended immediate, a jump target and an instruction class.
- Holds decoded entries in a small internal queue so fetch can run ahead while execute stalls.

Parameters:
- DATA_W, 32, width of extended immediate output; must be >= 32.
- PC_W, 32, width of program counter; must be >= 28.
- DEPTH, 2, decoded-entry queue depth; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous queue clear (branch mispredict / redirect).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  address of in_instr.
- out_valid  output  1  decoded entry available at head.
- out_ready  input  1  consumer takes head this cycle.
- out_opcode  output  6  instr[31:26].
- out_rs  output  5  instr[25:21].
- out_rt  output  5  instr[20:16].
- out_rd  output  5  instr[15:11].
- out_shamt  output  5  instr[10:6].
- out_funct  output  6  instr[5:0].
- out_imm_ext  output  DATA_W  extended immediate.
- out_jtarget  output  PC_W  computed jump target.
- out_class  output  3  instruction class code.
- out_pc  output  PC_W  PC of head entry.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst_n low at posedge): count=0, read/write pointers=0, out_valid=0, in_ready=1. Data outputs are 0 while empty.
- Push: occurs when in_valid && in_ready. Pop: occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). It is low when full, even if a pop happens the same cycle; there is no full pass-through.
- out_valid = (count != 0). The head's fields are driven from queue storage.
- Latency: an instruction accepted at edge N appears at the outputs after edge N, i.e. out_valid is seen in cycle N+1. There is no combinational in-to-out path.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- flush: count=0 and pointers reset at the edge. Any push in the same cycle is discarded. Priority order: rst_n > flush > push/pop.
- Decode is computed at push time and stored.
- Immediate extension:
  - andi/ori/xori (opcode 0x0C/0x0D/0x0E): zero-extend.
  - lui (0x0F): imm<<16, zero-filled to DATA_W.
  - All other opcodes: sign-extend.
- out_jtarget = {pc4[PC_W-1:28], instr[25:0], 2'b00}, where pc4 = in_pc + 4, truncated to PC_W. It is computed for every instruction and meaningful only for J/JAL.
- Class codes:
  - 0 R (opcode 0x00)
  - 1 J (0x02)
  - 2 JAL (0x03)
  - 3 BRANCH (0x04, 0x05)
  - 4 LOAD (0x23)
  - 5 STORE (0x2B)
  - 6 IMM (every other opcode)
  - 7 is reserved; see the optional feature.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes outside the supported set {0x00, 0x02–0x05, 0x08–0x0F, 0x23, 0x2B} get class 7 (ILLEGAL).
  - An extra output, illegal_seen (1 bit), is added. It is sticky and set when an illegal entry is pushed.
  - illegal_seen is cleared only by rst_n, not by flush.
- Undefined: those opcodes get class 6, and there is no illegal_seen port.

Decomposition:
- Package decode_pkg holds:
  - Opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW).
  - A class_t enum of 3 bits.
  - A decoded_t struct for the queue entry.
- One sub-module, decode_comb: pure combinational field, extension, target and class logic, instantiated on the push side.
- Queue control stays in decode_stage.

Test Plan:
- R-type: push 0x03E0E0EB → rs=31, rt=0, rd=28, shamt=3, funct=0x2B, class=0, out_valid one cycle after accept.
- Jump: push 0x0A970CE9 with pc=0x00400000 → out_jtarget=0x0A5C33A4, class=1. The same word with opcode 3 (0x0E970CE9) → same target, class=2.
- Load plus extension:
  - 0x8FE055A6 → rs=31, rt=0, imm_ext=0x000055A6, class=4.
  - addi with imm 0x8000 → 0xFFFF8000.
  - ori with imm 0x8000 → 0x00008000.
  - lui with imm 0x1234 → 0x12340000.
- Backpressure: out_ready=0, DEPTH=2, push three instructions → in_ready drops after the 2nd. Raise out_ready → entries pop in order, then the 3rd is accepted. Count is never greater than 2.
- Flush/reset: with count=2, assert flush together with in_valid → next cycle count=0, out_valid=0, and the pushed word is lost. Drop rst_n mid-stream → same result.
- With DECODE_ILLEGAL_TRAP_EN: push opcode 0x3F → class=7, illegal_seen=1, which persists after a flush.
